// File: rtl/mandel_pixel_scheduler.sv
// ============================================================================
// Module   : mandel_pixel_scheduler
// Brief    : Raster sequencer feeding a Mandelbrot depth calculator one pixel
//            at a time and streaming (x, y, depth) tuples downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandel_pixel_scheduler #(
  parameter int FRAC        = 28,
  parameter int WORD_LENGTH = 32,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [WORD_LENGTH-1:0] re_min,
  input  logic [WORD_LENGTH-1:0] im_max,
  input  logic [WORD_LENGTH-1:0] step,
  input  logic [9:0]             max_iter_in,
  output logic                   calc_start,
  output logic [9:0]             calc_x,
  output logic [8:0]             calc_y,
  output logic [WORD_LENGTH-1:0] calc_re_c,
  output logic [WORD_LENGTH-1:0] calc_im_c,
  output logic [9:0]             calc_max_iter,
  input  logic                   calc_done,
  input  logic [9:0]             calc_depth,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic [9:0]             pix_depth,
  output logic                   pix_last,
  output logic                   busy,
  output logic                   frame_done
);

  if (FRAC >= WORD_LENGTH || H_RES > 1024 || V_RES > 512 || H_RES < 1 || V_RES < 1)
  begin : g_param_check
    $error("mandel_pixel_scheduler: illegal parameter combination");
  end

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [9:0]             x_q, x_d;
  logic [8:0]             y_q, y_d;
  logic [WORD_LENGTH-1:0] re_q, re_d;
  logic [WORD_LENGTH-1:0] im_q, im_d;
  logic [WORD_LENGTH-1:0] re_min_q, re_min_d;
  logic [WORD_LENGTH-1:0] step_q, step_d;
  logic [9:0]             max_iter_q, max_iter_d;
  logic                   done_q, done_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [9:0]             pix_x_q, pix_x_d;
  logic [8:0]             pix_y_q, pix_y_d;
  logic [9:0]             pix_depth_q, pix_depth_d;
  logic                   pix_last_q, pix_last_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    re_d         = re_q;
    im_d         = im_q;
    re_min_d     = re_min_q;
    step_d       = step_q;
    max_iter_d   = max_iter_q;
    done_d       = calc_done;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_depth_d  = pix_depth_q;
    pix_last_d   = pix_last_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          re_min_d   = re_min;
          step_d     = step;
          max_iter_d = max_iter_in;
          x_d        = '0;
          y_d        = '0;
          re_d       = re_min;
          im_d       = im_max;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Only a fresh rise counts; a done level left over from the previous
        // pixel stays high across ISSUE and must not be taken as this result.
        if (calc_done && !done_q) begin
          pix_depth_d = calc_depth;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
          pix_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_last_q) begin
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            if (x_q == X_LAST) begin
              x_d  = '0;
              y_d  = y_q + 9'd1;
              re_d = re_min_q;
              im_d = im_q - step_q;
            end else begin
              x_d  = x_q + 10'd1;
              re_d = re_q + step_q;
            end
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      re_q         <= '0;
      im_q         <= '0;
      re_min_q     <= '0;
      step_q       <= '0;
      max_iter_q   <= '0;
      done_q       <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_depth_q  <= '0;
      pix_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      re_q         <= re_d;
      im_q         <= im_d;
      re_min_q     <= re_min_d;
      step_q       <= step_d;
      max_iter_q   <= max_iter_d;
      done_q       <= done_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_depth_q  <= pix_depth_d;
      pix_last_q   <= pix_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign calc_start    = (state_q == S_ISSUE);
  assign calc_x        = x_q;
  assign calc_y        = y_q;
  assign calc_re_c     = re_q;
  assign calc_im_c     = im_q;
  assign calc_max_iter = max_iter_q;
  assign pix_valid     = pix_valid_q;
  assign pix_x         = pix_x_q;
  assign pix_y         = pix_y_q;
  assign pix_depth     = pix_depth_q;
  assign pix_last      = pix_last_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mandel_pixel_scheduler.sv
// ============================================================================
// Module   : tb_mandel_pixel_scheduler
// Brief    : Scoreboard bench for mandel_pixel_scheduler on a 2x2 raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandel_pixel_scheduler;

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [31:0] re_min, im_max, step;
  logic [9:0]  max_iter_in;
  logic        calc_start;
  logic [9:0]  calc_x;
  logic [8:0]  calc_y;
  logic [31:0] calc_re_c, calc_im_c;
  logic [9:0]  calc_max_iter;
  logic        calc_done;
  logic [9:0]  calc_depth;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [9:0]  pix_depth;
  logic        pix_last;
  logic        busy;
  logic        frame_done;

  always #5 sysclk = ~sysclk;

  mandel_pixel_scheduler #(
    .FRAC(28), .WORD_LENGTH(32), .H_RES(2), .V_RES(2)
  ) dut (
    .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
    .re_min(re_min), .im_max(im_max), .step(step), .max_iter_in(max_iter_in),
    .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
    .calc_re_c(calc_re_c), .calc_im_c(calc_im_c), .calc_max_iter(calc_max_iter),
    .calc_done(calc_done), .calc_depth(calc_depth),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_depth(pix_depth), .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] re;
    logic [31:0] im;
    logic [9:0]  mi;
  } issue_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] depth;
    logic       last;
  } tuple_t;

  issue_t iq[$];
  tuple_t tq[$];
  int     passed = 0;
  int     total = 0;
  int     issue_count = 0;
  int     hs_count = 0;
  int     fd_count = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Calculator model: depth = x + 2y, done rises 7 cycles after start and
  // holds until the next start (or one cycle past it in stale_mode).
  logic [3:0] cnt = 4'd0;
  logic [9:0] mx = 10'd0;
  logic [8:0] my = 9'd0;
  logic       drop_pending = 1'b0;
  logic       stale_mode = 1'b0;
  initial begin
    calc_done  = 1'b0;
    calc_depth = 10'd0;
  end

  always @(posedge sysclk) begin
    if (calc_start) begin
      cnt <= 4'd7;
      mx  <= calc_x;
      my  <= calc_y;
      if (stale_mode) drop_pending <= 1'b1;
      else calc_done <= 1'b0;
    end else begin
      if (drop_pending) begin
        calc_done    <= 1'b0;
        drop_pending <= 1'b0;
      end
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          calc_done  <= 1'b1;
          calc_depth <= mx + {my, 1'b0};
        end
      end
    end
  end

  // Monitor: scores every calculator issue and every tuple handshake.
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (calc_start) begin
        issue_count++;
        if (iq.size() == 0) begin
          total++;
          $display("FAIL unexpected_issue: got x=%0d y=%0d expected no issue", calc_x, calc_y);
        end else begin
          issue_t e;
          e = iq.pop_front();
          check("issue", {calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter}, e);
        end
      end
      if (pix_valid && pix_ready) begin
        hs_count++;
        if (tq.size() == 0) begin
          total++;
          $display("FAIL unexpected_tuple: got x=%0d y=%0d d=%0d expected none", pix_x, pix_y, pix_depth);
        end else begin
          tuple_t t;
          t = tq.pop_front();
          check("tuple", {pix_x, pix_y, pix_depth, pix_last}, t);
        end
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic start_frame(input logic [31:0] rm, input logic [31:0] im,
                             input logic [31:0] st, input logic [9:0] mi);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 2; x++) begin
        issue_t e;
        tuple_t t;
        e.x = 10'(x); e.y = 9'(y);
        e.re = rm + 32'(x) * st;
        e.im = im - 32'(y) * st;
        e.mi = mi;
        t.x = 10'(x); t.y = 9'(y);
        t.depth = 10'(x + 2 * y);
        t.last = (x == 1) && (y == 1);
        iq.push_back(e);
        tq.push_back(t);
      end
    end
    re_min = rm; im_max = im; step = st; max_iter_in = mi;
    @(posedge sysclk); #1 frame_start = 1'b1;
    @(posedge sysclk); #1 frame_start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int fd0, input int hs0);
    for (int i = 0; i < 400 && fd_count == fd0; i++) @(negedge sysclk);
    check({tag, "_frame_done"}, 128'(fd_count), 128'(fd0 + 1));
    check({tag, "_busy_low"}, 128'(busy), 128'd0);
    repeat (20) @(negedge sysclk);
    check({tag, "_single_done"}, 128'(fd_count), 128'(fd0 + 1));
    check({tag, "_tuples"}, 128'(hs_count - hs0), 128'd4);
    check({tag, "_queues_empty"}, 128'(iq.size() + tq.size()), 128'd0);
  endtask

  initial begin
    int fd0, hs0, is0;
    reset_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
    re_min = '0; im_max = '0; step = '0; max_iter_in = '0;

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      @(posedge sysclk); #1;
      frame_start = 1'($urandom); pix_ready = 1'($urandom);
      re_min = $urandom; im_max = $urandom; step = $urandom; max_iter_in = 10'($urandom);
      @(negedge sysclk);
      check("reset_outputs", {calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
            pix_valid, pix_x, pix_y, pix_depth, pix_last, busy, frame_done}, 128'd0);
    end
    @(posedge sysclk); #1 frame_start = 1'b0; pix_ready = 1'b1; reset_n = 1'b1;
    repeat (5) @(negedge sysclk);
    check("idle_after_reset", {calc_start, busy, pix_valid}, 128'd0);

    // Basic frame.
    fd0 = fd_count; hs0 = hs_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    finish_frame("basic", fd0, hs0);

    // Backpressure on the second tuple.
    fd0 = fd_count; hs0 = hs_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    for (int i = 0; i < 100 && hs_count == hs0; i++) @(negedge sysclk);
    @(posedge sysclk); #1 pix_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if (pix_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge sysclk);
      check("stall_hold", {pix_valid, pix_x, pix_y, pix_depth, calc_start},
            {1'b1, 10'd1, 9'd0, 10'd1, 1'b0});
    end
    @(posedge sysclk); #1 pix_ready = 1'b1;
    finish_frame("stall", fd0, hs0);

    // frame_start during WAIT is ignored.
    fd0 = fd_count; hs0 = hs_count; is0 = issue_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    for (int i = 0; i < 100 && issue_count == is0; i++) @(negedge sysclk);
    @(posedge sysclk); #1;
    re_min = 32'h0000_0000; max_iter_in = 10'd5; frame_start = 1'b1;
    @(posedge sysclk); #1 frame_start = 1'b0;
    finish_frame("ignore_start", fd0, hs0);

    // Wrapping arithmetic and max_iter = 0 pass-through.
    fd0 = fd_count; hs0 = hs_count;
    start_frame(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 10'd0);
    finish_frame("wrap", fd0, hs0);

    // Stale done level held into the next pixel's WAIT.
    stale_mode = 1'b1;
    fd0 = fd_count; hs0 = hs_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    finish_frame("stale", fd0, hs0);
    stale_mode = 1'b0;

    // Reset mid-WAIT on pixel (1,0).
    fd0 = fd_count; is0 = issue_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    for (int i = 0; i < 100 && issue_count < is0 + 2; i++) @(negedge sysclk);
    @(posedge sysclk); #1;
    @(posedge sysclk); #1 reset_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
          pix_valid, pix_x, pix_y, pix_depth, pix_last, busy, frame_done}, 128'd0);
    iq.delete(); tq.delete();
    @(posedge sysclk); #1 reset_n = 1'b1;
    hs0 = hs_count; is0 = issue_count;
    repeat (15) @(negedge sysclk);
    check("no_stray_after_reset", 128'((hs_count - hs0) + (issue_count - is0) + int'(busy)), 128'd0);
    fd0 = fd_count;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 10'd100);
    finish_frame("after_reset", fd0, hs0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
Frame-level sequencer that sits directly upstream of the per-pixel Mandelbrot depth calculator.
- Walks the screen raster and computes each pixel's complex constant c in fixed point.
- Issues one calculation at a time to the calculator and collects the resulting depth.
- Emits (x, y, depth) tuples on a valid/ready stream to the colour-mapping/frame-buffer stage downstream.

Parameters:
FRAC, 28, fractional bits of the fixed-point format (matches calculator)
WORD_LENGTH, 32, total bits of re_c/im_c/step words
H_RES, 640, pixels per line (x range 0..H_RES-1, must fit 10 bits)
V_RES, 480, lines per frame (y range 0..V_RES-1, must fit 9 bits)

Ports:
sysclk  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  request a new frame; honoured only in IDLE
re_min  in  WORD_LENGTH  signed Re(c) of pixel x=0
im_max  in  WORD_LENGTH  signed Im(c) of line y=0
step  in  WORD_LENGTH  signed per-pixel increment (same in x and y)
max_iter_in  in  10  iteration limit for the frame
calc_start  out  1  one-cycle start pulse to calculator
calc_x  out  10  x of pixel in flight
calc_y  out  9  y of pixel in flight
calc_re_c  out  WORD_LENGTH  Re(c) of pixel in flight
calc_im_c  out  WORD_LENGTH  Im(c) of pixel in flight
calc_max_iter  out  10  latched max_iter for calculator
calc_done  in  1  calculator done level
calc_depth  in  10  calculator final depth, valid when calc_done rises
pix_valid  out  1  output tuple valid
pix_ready  in  1  downstream accepts tuple
pix_x  out  10  tuple x
pix_y  out  9  tuple y
pix_depth  out  10  tuple depth
pix_last  out  1  tuple is pixel (H_RES-1, V_RES-1)
busy  out  1  high from frame acceptance until frame_done
frame_done  out  1  one-cycle pulse after last tuple handshake

Behaviour:
- Reset (reset_n low, async): state IDLE; every output 0; internal done_q, counters and accumulators 0.
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE, frame_start=1:
  - Latch re_min, im_max, step and max_iter_in.
  - Load x=0, y=0, calc_re_c=re_min, calc_im_c=im_max.
  - Assert busy and go to ISSUE.
  - frame_start is ignored in every other state.
- ISSUE: calc_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - done_q registers calc_done every cycle in every state.
  - Capture occurs only on a rising edge (calc_done=1 and done_q=0). A stale high done left over from the previous pixel is never captured.
  - On the rising edge: pix_depth<=calc_depth; pix_x/pix_y<=calc_x/calc_y; pix_last<=(x==H_RES-1 && y==V_RES-1); pix_valid<=1; go to EMIT.
- EMIT:
  - pix_valid and all pix_* held stable until pix_ready=1.
  - No calc_start is issued while the tuple is pending.
  - On handshake (pix_valid && pix_ready): pix_valid<=0.
    - If pix_last: busy<=0, frame_done=1 for one cycle, go to IDLE.
    - Else advance coordinates and go to ISSUE.
- Coordinate advance:
  - x<H_RES-1: x+1; calc_re_c+=step.
  - x==H_RES-1: x=0; y+1; calc_re_c=re_min latched; calc_im_c-=step.
  - Additions wrap modulo 2^WORD_LENGTH (two's complement); no saturation.
  - No multiplier is used.
- calc_x, calc_y, calc_re_c, calc_im_c and calc_max_iter are stable from ISSUE through WAIT.
- Per-pixel overhead beyond calculator time, with pix_ready held high:
  - 1 cycle ISSUE.
  - 1 cycle edge detect.
  - 1 cycle EMIT.
- max_iter_in=0 is passed through unchanged; the calculator's behaviour defines the depth.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The next frame restarts at (0,0). Any in-flight calculator result is discarded, because the edge detector requires a fresh rise after ISSUE.
- pix_ready high outside EMIT has no effect.

Test Plan:
1. Assert reset_n=0 with random inputs -> every output 0; after release, state stays IDLE with calc_start=0 until frame_start.
2. H_RES=2, V_RES=2, re_min=0xE0000000 (-2.0), im_max=0x10000000 (1.0), step=0x08000000 (0.5); calculator model returns depth=x+2y after 7 cycles; pix_ready=1 -> issues (0,0,-2.0,1.0), (1,0,-1.5,1.0), (0,1,-2.0,0.5), (1,1,-1.5,0.5); depths 0,1,2,3; pix_last only on 4th; single frame_done pulse; busy low afterwards.
3. Same frame with pix_ready low for 5 cycles on the 2nd tuple -> pix_valid high and pix_x/y/depth unchanged for those 5 cycles; no calc_start until the cycle after the handshake.
4. frame_start pulsed during WAIT with different re_min -> ignored; current frame completes with the original values and exactly 4 tuples.
5. Model holds calc_done high from the previous pixel into the next ISSUE and drops it one cycle later -> no tuple until the following rise; captured depth belongs to the new pixel.
6. Assert reset_n=0 mid-WAIT on pixel (1,0), release, then frame_start -> first calc_start carries x=0, y=0, re_c=re_min; no stray tuple from the aborted pixel.
